// File: rtl/hs_rx_pkg.sv
// Shared types and constants for the HS receive sequencer.
// States, default sync byte, byte counter width and a saturating increment.
package hs_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HUNT,
        RECV,
        DRAIN,
        WAIT_LP
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB8;
    localparam int         BYTE_CNT_W        = 16;

    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hs_rx_trail_buf.sv
// Fixed-depth byte delay line: a byte leaves only when DEPTH newer bytes have been pushed.
// Flush empties the line so the tail of a burst never emerges.
module hs_rx_trail_buf #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] fill_reg;
    logic          full;

    assign full = (fill_reg == CW'(DEPTH));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [7:0] data_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)    data_reg <= 8'd0;
                    else if (push) data_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)    data_reg <= 8'd0;
                    else if (push) data_reg <= g_stage[gi-1].data_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fill_reg <= '0;
        else if (flush)          fill_reg <= '0;
        else if (push && !full)  fill_reg <= fill_reg + 1'b1;
    end

    // Oldest byte is only valid in the cycle it is pushed out by a newer one.
    assign dout       = g_stage[DEPTH-1].data_reg;
    assign dout_valid = push && full;

endmodule

// File: rtl/hs_rx_sequencer.sv
// HS receive byte sequencer: settle, sync hunt, payload forwarding to the FIFO, SoT/EoT and errors.
// Define HS_RX_TRAIL_STRIP_EN to strip the last TRAIL_BYTES bytes of every burst.
module hs_rx_sequencer
    import hs_rx_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 8,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         SYNC_TIMEOUT  = 4,
    parameter int         TRAIL_BYTES   = 2
) (
    input  logic                  RxDDRClkHS,
    input  logic                  RST,
    input  logic                  HS_REQ,
    input  logic                  FLAG_DESERIALIZE,
    input  logic [7:0]            P_DATA,
    input  logic                  FIFO_FULL,
    input  logic                  CLR_ERR,
    output logic                  DESER_EN,
    output logic                  WR_EN,
    output logic [7:0]            WR_DATA,
    output logic                  SOT_DET,
    output logic                  EOT_DET,
    output logic                  SYNC_ERR,
    output logic                  OVF_ERR,
    output logic [BYTE_CNT_W-1:0] BYTE_CNT,
    output logic                  BUSY
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be 1..255");
    end
    if (SYNC_TIMEOUT < 1 || SYNC_TIMEOUT > 15) begin : g_bad_timeout
        $error("SYNC_TIMEOUT must be 1..15");
    end
    if (TRAIL_BYTES < 1 || TRAIL_BYTES > 4) begin : g_bad_trail
        $error("TRAIL_BYTES must be 1..4");
    end

    state_t                state_reg, state_next;
    logic [7:0]            settle_cnt_reg;
    logic [3:0]            hunt_cnt_reg;
    logic                  sync_match, hunt_timeout, settle_done;
    logic                  recv_byte, cand_valid, do_write, do_drop;
    logic [7:0]            cand_data;
    logic                  wr_en_reg, sot_reg, eot_reg, sync_err_reg, ovf_err_reg;
    logic [7:0]            wr_data_reg;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;

    assign sync_match   = FLAG_DESERIALIZE && (P_DATA == SYNC_BYTE);
    assign hunt_timeout = FLAG_DESERIALIZE && !sync_match &&
                          (({1'b0, hunt_cnt_reg} + 5'd1) == 5'(SYNC_TIMEOUT));
    assign settle_done  = (settle_cnt_reg == 8'd0);
    assign recv_byte    = (state_reg == RECV) && FLAG_DESERIALIZE;

`ifdef HS_RX_TRAIL_STRIP_EN
    hs_rx_trail_buf #(
        .DEPTH (TRAIL_BYTES)
    ) u_trail_buf (
        .clk        (RxDDRClkHS),
        .rst_n      (RST),
        .push       (recv_byte),
        .flush      (state_reg != RECV),
        .din        (P_DATA),
        .dout       (cand_data),
        .dout_valid (cand_valid)
    );
`else
    assign cand_valid = recv_byte;
    assign cand_data  = P_DATA;
`endif

    // Fullness is judged where the byte would leave towards the FIFO.
    assign do_write = cand_valid && !FIFO_FULL;
    assign do_drop  = cand_valid && FIFO_FULL;

    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (HS_REQ) state_next = SETTLE;
            SETTLE:  if (!HS_REQ) state_next = IDLE;
                     else if (settle_done) state_next = HUNT;
            HUNT:    if (!HS_REQ) state_next = IDLE;
                     else if (sync_match) state_next = RECV;
                     else if (hunt_timeout) state_next = WAIT_LP;
            RECV:    if (!HS_REQ) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            WAIT_LP: if (!HS_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        DESER_EN = 1'b0;
        BUSY     = (state_reg != IDLE);
        case (state_reg)
            HUNT, RECV: DESER_EN = 1'b1;
            default:    DESER_EN = 1'b0;
        endcase
    end

    // Counters are preloaded in IDLE so SETTLE and HUNT always start fresh.
    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            settle_cnt_reg <= 8'd0;
            hunt_cnt_reg   <= 4'd0;
        end else begin
            if (state_reg == IDLE) begin
                settle_cnt_reg <= 8'(SETTLE_CYCLES);
                hunt_cnt_reg   <= 4'd0;
            end else begin
                if (state_reg == SETTLE && !settle_done)
                    settle_cnt_reg <= settle_cnt_reg - 8'd1;
                if (state_reg == HUNT && HS_REQ && FLAG_DESERIALIZE && !sync_match)
                    hunt_cnt_reg <= hunt_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= 8'd0;
            sot_reg      <= 1'b0;
            eot_reg      <= 1'b0;
            sync_err_reg <= 1'b0;
            ovf_err_reg  <= 1'b0;
            byte_cnt_reg <= '0;
        end else begin
            wr_en_reg <= do_write;
            if (do_write) wr_data_reg <= cand_data;
            sot_reg <= (state_reg == HUNT) && (state_next == RECV);
            eot_reg <= (state_reg == DRAIN);

            if ((state_reg == HUNT) && (state_next == RECV))
                byte_cnt_reg <= '0;
            else if (do_write)
                byte_cnt_reg <= sat_inc(byte_cnt_reg);

            // A fresh error outranks a simultaneous clear.
            if ((state_reg == HUNT) && (state_next == WAIT_LP)) sync_err_reg <= 1'b1;
            else if (CLR_ERR)                                   sync_err_reg <= 1'b0;

            if (do_drop)      ovf_err_reg <= 1'b1;
            else if (CLR_ERR) ovf_err_reg <= 1'b0;
        end
    end

    assign WR_EN    = wr_en_reg;
    assign WR_DATA  = wr_data_reg;
    assign SOT_DET  = sot_reg;
    assign EOT_DET  = eot_reg;
    assign SYNC_ERR = sync_err_reg;
    assign OVF_ERR  = ovf_err_reg;
    assign BYTE_CNT = byte_cnt_reg;

endmodule
